// File: rtl/memory_arbiter_pkg.sv
// Shared types and constants for memory_arbiter: FSM states, access owner,
// and the latency counter sizing.
package memory_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RESPOND = 2'd2
  } arbState_t;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } owner_t;

  localparam int MEMORY_LATENCY_MAX = 4;
  localparam int COUNTER_WIDTH      = 3;

endpackage

// File: rtl/memory_arbiter_latency_counter.sv
// Down-counter timing one RAM access: loaded on grant, decremented while the
// access is in flight; expire marks the capture cycle (count == 1).
module memory_arbiter_latency_counter
  import memory_arbiter_pkg::*;
(
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     load,
  input  logic [COUNTER_WIDTH-1:0] loadValue,
  input  logic                     decrement,
  output logic [COUNTER_WIDTH-1:0] count,
  output logic                     expire
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= loadValue;
    end else if (decrement && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expire = (count == COUNTER_WIDTH'(1));

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between instruction fetch and data load/store,
// data has fixed priority. Define MEMORY_ARBITER_DEBUG_EN for grant/conflict counters.
module memory_arbiter
  import memory_arbiter_pkg::*;
#(
  parameter int MEMORY_LATENCY = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        fetch_request,
  input  logic [31:0] fetch_address,
  output logic        fetch_ready,
  output logic [31:0] fetch_data,
  input  logic        data_request,
  input  logic        data_write,
  input  logic [31:0] data_address,
  input  logic [31:0] data_writeData,
  output logic        data_ready,
  output logic [31:0] data_readData,
  output logic        ram_enable,
  output logic        ram_write,
  output logic [31:0] ram_address,
  output logic [31:0] ram_writeData,
  input  logic [31:0] ram_readData,
  output logic        shouldStall
`ifdef MEMORY_ARBITER_DEBUG_EN
  ,
  output logic [31:0] debug_fetchGrants,
  output logic [31:0] debug_dataGrants,
  output logic [31:0] debug_conflicts
`endif
);

  localparam logic [COUNTER_WIDTH-1:0] LATENCY_LOAD = COUNTER_WIDTH'(MEMORY_LATENCY);

  arbState_t state;
  arbState_t stateNext;
  owner_t    owner;
  logic [31:0] addressQ;
  logic [31:0] writeDataQ;
  logic        writeQ;
  logic [COUNTER_WIDTH-1:0] count;
  logic        expire;
  logic        dataAllowed;
  logic        fetchAllowed;
  logic        grantData;
  logic        grantFetch;
  logic        grant;

  // In RESPOND the current owner is still reacting to its ready pulse, so only
  // the other requester may be granted. Grants are suppressed while in reset.
  assign dataAllowed  = (state == IDLE) || (state == RESPOND && owner == FETCH);
  assign fetchAllowed = (state == IDLE) || (state == RESPOND && owner == DATA);
  assign grantData    = reset && dataAllowed && data_request;
  assign grantFetch   = reset && fetchAllowed && fetch_request && !grantData;
  assign grant        = grantData || grantFetch;

  memory_arbiter_latency_counter u_latencyCounter (
    .clock     (clock),
    .reset     (reset),
    .load      (grant),
    .loadValue (LATENCY_LOAD),
    .decrement (state == ACCESS),
    .count     (count),
    .expire    (expire)
  );

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = grant ? ACCESS : IDLE;
      ACCESS:  stateNext = expire ? RESPOND : ACCESS;
      RESPOND: stateNext = grant ? ACCESS : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      owner         <= FETCH;
      addressQ      <= '0;
      writeDataQ    <= '0;
      writeQ        <= 1'b0;
      fetch_data    <= '0;
      data_readData <= '0;
    end else begin
      state <= stateNext;
      if (grantData) begin
        owner      <= DATA;
        addressQ   <= data_address;
        writeDataQ <= data_writeData;
        writeQ     <= data_write;
      end else if (grantFetch) begin
        owner    <= FETCH;
        addressQ <= fetch_address;
        writeQ   <= 1'b0;
      end
      if (state == ACCESS && expire) begin
        if (owner == FETCH) begin
          fetch_data <= ram_readData;
        end else if (!writeQ) begin
          data_readData <= ram_readData;
        end
      end
    end
  end

  // The RAM sees the request itself in the grant cycle, the latched copy afterwards.
  assign ram_enable    = grant;
  assign ram_write     = grantData && data_write;
  assign ram_address   = grantData ? data_address : (grantFetch ? fetch_address : addressQ);
  assign ram_writeData = grantData ? data_writeData : writeDataQ;

  assign fetch_ready = (state == RESPOND) && (owner == FETCH);
  assign data_ready  = (state == RESPOND) && (owner == DATA);
  assign shouldStall = (fetch_request && !fetch_ready) || (data_request && !data_ready);

`ifdef MEMORY_ARBITER_DEBUG_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      debug_fetchGrants <= '0;
      debug_dataGrants  <= '0;
      debug_conflicts   <= '0;
    end else begin
      if (grantFetch) debug_fetchGrants <= debug_fetchGrants + 32'd1;
      if (grantData)  debug_dataGrants  <= debug_dataGrants + 32'd1;
      if (fetch_request && data_request && !grantFetch) begin
        debug_conflicts <= debug_conflicts + 32'd1;
      end
    end
  end
`endif

endmodule
